// File: rtl/tone_period_meter.sv
// ============================================================================
// Module  : tone_period_meter
// Brief   : Deglitched rising-edge period meter for a 1-bit square-wave tone,
//           classifying each period against 8 power-of-two button tones.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tone_period_meter #(
    parameter int CNT_W     = 18,
    parameter int GLITCH    = 4,
    parameter int TIMEOUT   = 200000,
    parameter int BASE_LOG2 = 10,
    parameter int TOL_SHIFT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             audio_in,
    output logic [CNT_W-1:0] period_o,
    output logic             valid_o,
    output logic [2:0]       tone_idx_o,
    output logic             tone_hit_o,
    output logic             silent_o
);

    localparam int               STAB_W    = $clog2(GLITCH + 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(GLITCH - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_MEAS  = 2'd2
    } state_t;

    logic              sync1_q, sync2_q;
    logic              filt_q, filt_dly_q;
    logic [STAB_W-1:0] stab_q;
    logic [CNT_W-1:0]  cnt_q;
    state_t            state_q;
    logic              rise;
    logic [CNT_W:0]    cnt_ext;
    logic [7:0]        match;
    logic              hit_d;
    logic [2:0]        idx_d;

    // Synchronizer plus stability filter: a level change is accepted only
    // after GLITCH consecutive samples disagree with the filtered level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            filt_q     <= 1'b0;
            filt_dly_q <= 1'b0;
            stab_q     <= '0;
        end else begin
            sync1_q    <= audio_in;
            sync2_q    <= sync1_q;
            filt_dly_q <= filt_q;
            if (sync2_q != filt_q) begin
                if (stab_q == STAB_LAST) begin
                    filt_q <= sync2_q;
                    stab_q <= '0;
                end else begin
                    stab_q <= stab_q + STAB_W'(1);
                end
            end else begin
                stab_q <= '0;
            end
        end
    end

    assign rise = filt_q & ~filt_dly_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (rise) begin
            cnt_q <= CNT_W'(1);
        end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign cnt_ext = {1'b0, cnt_q};

    for (genvar k = 0; k < 8; k++) begin : g_tone
        localparam logic [CNT_W:0] NOM = (CNT_W + 1)'(1) << (k + BASE_LOG2);
        localparam logic [CNT_W:0] TOL = NOM >> TOL_SHIFT;
        logic [CNT_W:0] diff;
        assign diff     = (cnt_ext >= NOM) ? (cnt_ext - NOM) : (NOM - cnt_ext);
        assign match[k] = (diff <= TOL);
    end

    // Descending scan so the lowest matching tone index is the one kept.
    always_comb begin
        hit_d = 1'b0;
        idx_d = tone_idx_o;
        for (int k = 7; k >= 0; k--) begin
            if (match[k]) begin
                hit_d = 1'b1;
                idx_d = 3'(k);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            period_o   <= '0;
            valid_o    <= 1'b0;
            tone_idx_o <= 3'd0;
            tone_hit_o <= 1'b0;
            silent_o   <= 1'b1;
        end else begin
            valid_o <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (rise) begin
                        state_q <= S_ARMED;
                    end
                end
                S_ARMED, S_MEAS: begin
                    // A rise on the timeout cycle still counts as a measurement.
                    if (rise) begin
                        state_q    <= S_MEAS;
                        period_o   <= cnt_q;
                        valid_o    <= 1'b1;
                        silent_o   <= 1'b0;
                        tone_hit_o <= hit_d;
                        tone_idx_o <= idx_d;
                    end else if (cnt_q == TIMEOUT_C) begin
                        state_q    <= S_IDLE;
                        silent_o   <= 1'b1;
                        tone_hit_o <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
